// File: rtl/sprite_dma_pkg.sv
// Shared types and default sizing for the sprite read master and its FIFO.
package sprite_dma_pkg;

    // Top-level sequencing: wait for go, issue bursts, wait for data to drain.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_MAX_BURST  = 4;
    localparam int DEF_FIFO_DEPTH = 32;

endpackage

// File: rtl/sprite_fifo.sv
// Show-ahead FIFO: the head word is presented on o_rdata whenever the FIFO
// is non-empty, and a pop simply advances to the next word.
module sprite_fifo
    import sprite_dma_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = DEF_FIFO_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_used
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_used;
    logic              w_do_push;
    logic              w_do_pop;

    // A pop on an empty FIFO (including the cycle a first word is pushed) is dropped.
    always_comb begin
        w_do_push = i_push && (r_used != CNT_W'(DEPTH));
        w_do_pop  = i_pop && (r_used != '0);
    end

    // Storage array; no reset so it maps onto plain RAM.
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_used <= r_used + CNT_W'(1);
                2'b01:   r_used <= r_used - CNT_W'(1);
                default: r_used <= r_used;
            endcase
        end
    end

    // Head word is forced to zero while empty so the output is clean after reset.
    always_comb begin
        o_empty = (r_used == '0);
        o_used  = r_used;
        o_rdata = '0;
        if (r_used != '0) begin
            o_rdata = r_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/sprite_read_master.sv
// Avalon-MM burst read master feeding sprite pixel bytes to the sprite
// controller through a show-ahead FIFO. Bursts are only issued when the FIFO
// has room for every word already requested plus the new burst.
module sprite_read_master
    import sprite_dma_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 8,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int BURST_W    = 3,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] control_read_base,
    input  logic [31:0]       control_read_length,
    input  logic              control_go,
    output logic              control_done,
    output logic              control_early_done,
    input  logic              user_read_buffer,
    output logic [DATA_W-1:0] user_buffer_output_data,
    output logic              user_data_available,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic [BURST_W-1:0] master_burstcount,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    input  logic              master_waitrequest
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_remaining;
    logic [CNT_W-1:0]   r_outstanding;
    logic               r_master_read;
    logic [ADDR_W-1:0]  r_master_address;
    logic [BURST_W-1:0] r_master_burstcount;
    logic               r_done;
    logic               r_early_done;

    logic               w_accept;
    logic               w_push;
    logic [CNT_W-1:0]   w_out_next;
    logic [ADDR_W-1:0]  w_addr_base;
    logic [31:0]        w_rem_base;
    logic [BURST_W-1:0] w_burst_next;
    logic [31:0]        w_committed;
    logic               w_credit_ok;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_used;
    logic [DATA_W-1:0]  w_fifo_rdata;

    function automatic logic [BURST_W-1:0] burst_size(input logic [31:0] rem);
        if (rem >= 32'(MAX_BURST)) begin
            burst_size = BURST_W'(MAX_BURST);
        end else begin
            burst_size = rem[BURST_W-1:0];
        end
    endfunction

    // Acceptance, response bookkeeping and the credit check for the next burst.
    // Words already in the FIFO plus words still owed by the slave plus the
    // candidate burst must fit in the FIFO, so a push can never be refused.
    always_comb begin
        w_accept     = r_master_read && !master_waitrequest;
        w_push       = master_readdatavalid && (r_outstanding != '0);
        w_out_next   = r_outstanding
                     + (w_accept ? CNT_W'(r_master_burstcount) : CNT_W'(0))
                     - CNT_W'(w_push);
        w_rem_base   = w_accept ? (r_remaining - 32'(r_master_burstcount)) : r_remaining;
        w_addr_base  = w_accept ? (r_addr + ADDR_W'(r_master_burstcount)) : r_addr;
        w_burst_next = burst_size(w_rem_base);
        w_committed  = 32'(w_fifo_used) + 32'(w_push) + 32'(w_out_next) + 32'(w_burst_next);
        w_credit_ok  = (w_committed <= 32'(FIFO_DEPTH));
    end

    // Control FSM with registered Avalon and status outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state             <= IDLE;
            r_addr              <= '0;
            r_remaining         <= '0;
            r_outstanding       <= '0;
            r_master_read       <= 1'b0;
            r_master_address    <= '0;
            r_master_burstcount <= '0;
            r_done              <= 1'b1;
            r_early_done        <= 1'b1;
        end else begin
            r_outstanding <= w_out_next;
            case (r_state)
                IDLE: begin
                    if (control_go && (control_read_length != '0)) begin
                        r_state             <= ISSUE;
                        r_addr              <= control_read_base;
                        r_remaining         <= control_read_length;
                        r_master_read       <= 1'b1;
                        r_master_address    <= control_read_base;
                        r_master_burstcount <= burst_size(control_read_length);
                        r_done              <= 1'b0;
                        r_early_done        <= 1'b0;
                    end
                end
                ISSUE: begin
                    // A stalled request is held untouched; otherwise plan the next one.
                    if (!r_master_read || w_accept) begin
                        r_addr      <= w_addr_base;
                        r_remaining <= w_rem_base;
                        if (w_rem_base == '0) begin
                            r_state       <= DRAIN;
                            r_master_read <= 1'b0;
                            r_early_done  <= 1'b1;
                        end else if (w_credit_ok) begin
                            r_master_read       <= 1'b1;
                            r_master_address    <= w_addr_base;
                            r_master_burstcount <= w_burst_next;
                        end else begin
                            r_master_read <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if ((r_outstanding == '0) && w_fifo_empty) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    sprite_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_wdata (master_readdata),
        .i_pop   (user_read_buffer),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_used  (w_fifo_used)
    );

    // Output mapping.
    always_comb begin
        master_read             = r_master_read;
        master_address          = r_master_address;
        master_burstcount       = r_master_burstcount;
        control_done            = r_done;
        control_early_done      = r_early_done;
        user_data_available     = !w_fifo_empty;
        user_buffer_output_data = w_fifo_rdata;
    end

endmodule

// File: tb/tb_sprite_read_master.sv
// Bench for sprite_read_master: an SDRAM slave model with fixed two-cycle
// latency and optional stalls, a user popper, and per-scenario tasks that
// compare recorded bursts and delivered bytes against the expected stream.
module tb_sprite_read_master;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] control_read_base = '0;
    logic [31:0] control_read_length = '0;
    logic        control_go = 1'b0;
    logic        control_done;
    logic        control_early_done;
    logic        user_read_buffer = 1'b0;
    logic [7:0]  user_buffer_output_data;
    logic        user_data_available;
    logic [31:0] master_address;
    logic        master_read;
    logic [2:0]  master_burstcount;
    logic [7:0]  master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_waitrequest = 1'b0;

    always #5 Clk = ~Clk;

    sprite_read_master dut (
        .Clk                     (Clk),
        .Reset                   (Reset),
        .control_read_base       (control_read_base),
        .control_read_length     (control_read_length),
        .control_go              (control_go),
        .control_done            (control_done),
        .control_early_done      (control_early_done),
        .user_read_buffer        (user_read_buffer),
        .user_buffer_output_data (user_buffer_output_data),
        .user_data_available     (user_data_available),
        .master_address          (master_address),
        .master_read             (master_read),
        .master_burstcount       (master_burstcount),
        .master_readdata         (master_readdata),
        .master_readdatavalid    (master_readdatavalid),
        .master_waitrequest      (master_waitrequest)
    );

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    int          pop_mode = 0;     // 0: pop while pop_budget>0, 1: always, 2: random
    int          pop_budget = 0;
    bit          rand_wait = 1'b0;
    int          stall_left = 0;
    logic [31:0] acc_addr_q[$];
    int          acc_bc_q[$];
    int          acc_cyc_q[$];
    logic [31:0] resp_q[$];
    int          ready_q[$];
    int          last_ready = 0;
    logic [7:0]  pop_q[$];
    int          last_pop_cyc = 0;
    int          acc_words = 0;
    int          inflight = 0;
    int          max_inflight = 0;
    int          hold_err = 0;
    int          read_cycles = 0;
    int          done_low_cycles = 0;
    int          avail_cycles = 0;
    int          early_rise_cyc = -1;
    int          done_rise_cyc = -1;
    bit          prev_stall = 1'b0;
    bit          prev_early = 1'b1;
    bit          prev_done = 1'b1;
    logic [31:0] prev_addr = '0;
    logic [2:0]  prev_bc = '0;

    function automatic logic [7:0] mdata(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Expected stream: bursts of up to 4 at base, base+4, ... and bytes mdata(base+i).
    function automatic int stream_errs(input logic [31:0] base, input int len);
        int e;
        int nb;
        int want_bc;
        e  = 0;
        nb = (len + 3) / 4;
        if (acc_addr_q.size() != nb) e++;
        else begin
            for (int k = 0; k < nb; k++) begin
                want_bc = (len - 4 * k >= 4) ? 4 : len - 4 * k;
                if (acc_addr_q[k] !== base + 32'(4 * k) || acc_bc_q[k] != want_bc) e++;
            end
        end
        if (pop_q.size() != len) e++;
        else begin
            for (int i = 0; i < len; i++) begin
                if (pop_q[i] !== mdata(base + 32'(i))) e++;
            end
        end
        return e;
    endfunction

    // Slave and user model; drives inputs on the falling edge.
    always @(negedge Clk) begin
        cyc++;
        if (prev_stall && (master_read !== 1'b1 || master_address !== prev_addr ||
                           master_burstcount !== prev_bc)) hold_err++;
        if (control_early_done === 1'b1 && !prev_early) early_rise_cyc = cyc;
        if (control_done === 1'b1 && !prev_done) done_rise_cyc = cyc;
        prev_early = (control_early_done === 1'b1);
        prev_done  = (control_done === 1'b1);
        if (control_done !== 1'b1) done_low_cycles++;
        if (user_data_available === 1'b1) avail_cycles++;
        if (master_read === 1'b1) read_cycles++;

        if (master_read === 1'b1 && stall_left > 0) begin
            master_waitrequest = 1'b1;
            stall_left--;
        end else begin
            master_waitrequest = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        prev_stall = (master_read === 1'b1) && master_waitrequest;
        prev_addr  = master_address;
        prev_bc    = master_burstcount;

        if (Reset && master_read === 1'b1 && !master_waitrequest) begin
            acc_addr_q.push_back(master_address);
            acc_bc_q.push_back(int'(master_burstcount));
            acc_cyc_q.push_back(cyc);
            acc_words += int'(master_burstcount);
            for (int i = 0; i < int'(master_burstcount); i++) begin
                int t;
                t = (cyc + 2 > last_ready + 1) ? cyc + 2 : last_ready + 1;
                resp_q.push_back(master_address + 32'(i));
                ready_q.push_back(t);
                last_ready = t;
            end
        end

        if (resp_q.size() > 0 && ready_q[0] <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata      = mdata(resp_q.pop_front());
            void'(ready_q.pop_front());
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = 8'($urandom);
        end

        case (pop_mode)
            1:       user_read_buffer = 1'b1;
            2:       user_read_buffer = 1'($urandom_range(0, 1));
            default: user_read_buffer = (pop_budget > 0);
        endcase
        if (Reset && user_read_buffer && user_data_available === 1'b1) begin
            pop_q.push_back(user_buffer_output_data);
            last_pop_cyc = cyc;
            if (pop_mode == 0) pop_budget--;
        end
        inflight = acc_words - pop_q.size();
        if (inflight > max_inflight) max_inflight = inflight;
    end

    task automatic clear_model();
        @(posedge Clk); #1;
        acc_addr_q.delete(); acc_bc_q.delete(); acc_cyc_q.delete(); pop_q.delete();
        acc_words = 0; max_inflight = 0; hold_err = 0; read_cycles = 0;
        done_low_cycles = 0; avail_cycles = 0; early_rise_cyc = -1; done_rise_cyc = -1;
    endtask

    task automatic start_xfer(input logic [31:0] base, input logic [31:0] len);
        @(posedge Clk); #1;
        control_read_base   = base;
        control_read_length = len;
        control_go          = 1'b1;
        @(posedge Clk); #1;
        control_go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge Clk); #1;
            if (control_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge Clk); #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        total++; if (master_read !== 1'b0) begin bad++; $display("FAIL rst_read got=%0b want=0", master_read); end
        total++; if (master_address !== 32'h0) begin bad++; $display("FAIL rst_addr got=%0h want=0", master_address); end
        total++; if (master_burstcount !== 3'd0) begin bad++; $display("FAIL rst_bc got=%0d want=0", master_burstcount); end
        total++; if (control_done !== 1'b1 || control_early_done !== 1'b1) begin bad++; $display("FAIL rst_done got=%0b/%0b want=1/1", control_done, control_early_done); end
        total++; if (user_data_available !== 1'b0 || user_buffer_output_data !== 8'h0) begin bad++; $display("FAIL rst_user got=%0b/%0h want=0/0", user_data_available, user_buffer_output_data); end
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
    endtask

    task automatic test_basic();
        bit ok;
        clear_model();
        pop_mode = 1;
        start_xfer(32'h1000, 12);
        total++; if (control_done !== 1'b0 || control_early_done !== 1'b0) begin bad++; $display("FAIL basic_go_drop got=%0b/%0b want=0/0", control_done, control_early_done); end
        wait_done(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=0 want=1"); end
        total++; if (acc_addr_q.size() != 3) begin bad++; $display("FAIL basic_nbursts got=%0d want=3", acc_addr_q.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                total++; if (acc_addr_q[k] !== 32'h1000 + 32'(4 * k) || acc_bc_q[k] != 4) begin bad++; $display("FAIL basic_burst%0d got=%0h/%0d want=%0h/4", k, acc_addr_q[k], acc_bc_q[k], 32'h1000 + 32'(4 * k)); end
            end
            total++; if (early_rise_cyc != acc_cyc_q[2] + 1) begin bad++; $display("FAIL basic_early got=%0d want=%0d", early_rise_cyc, acc_cyc_q[2] + 1); end
        end
        total++; if (pop_q.size() != 12) begin bad++; $display("FAIL basic_nbytes got=%0d want=12", pop_q.size()); end
        else begin
            for (int i = 0; i < 12; i++) begin
                total++; if (pop_q[i] !== mdata(32'h1000 + 32'(i))) begin bad++; $display("FAIL basic_byte%0d got=%0h want=%0h", i, pop_q[i], mdata(32'h1000 + 32'(i))); end
            end
        end
        total++; if (done_rise_cyc != last_pop_cyc + 2) begin bad++; $display("FAIL basic_done_time got=%0d want=%0d", done_rise_cyc, last_pop_cyc + 2); end
        total++; if (user_data_available !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0b want=0", user_data_available); end
    endtask

    task automatic test_short();
        bit ok;
        logic [31:0] base;
        clear_model();
        base = $urandom;
        pop_mode = 1;
        start_xfer(base, 6);
        wait_done(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL short_timeout got=0 want=1"); end
        total++; if (stream_errs(base, 6) != 0) begin bad++; $display("FAIL short_stream got=%0d errors want=0", stream_errs(base, 6)); end
        total++; if (acc_words != 6) begin bad++; $display("FAIL short_words got=%0d want=6", acc_words); end
    endtask

    task automatic test_stall();
        bit ok;
        int n_first;
        clear_model();
        pop_mode = 1;
        stall_left = 3;
        start_xfer(32'h3000, 8);
        wait_done(300, ok);
        n_first = 0;
        foreach (acc_addr_q[k]) if (acc_addr_q[k] === 32'h3000) n_first++;
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=0 want=1"); end
        total++; if (hold_err != 0) begin bad++; $display("FAIL stall_hold got=%0d changes want=0", hold_err); end
        total++; if (n_first != 1) begin bad++; $display("FAIL stall_accepts got=%0d want=1", n_first); end
        total++; if (read_cycles != 5) begin bad++; $display("FAIL stall_read_cycles got=%0d want=5", read_cycles); end
        total++; if (stream_errs(32'h3000, 8) != 0) begin bad++; $display("FAIL stall_stream got=%0d errors want=0", stream_errs(32'h3000, 8)); end
    endtask

    task automatic test_credit();
        bit ok;
        clear_model();
        pop_mode = 0;
        pop_budget = 0;
        start_xfer(32'h4000, 40);
        repeat (60) @(posedge Clk);
        #1;
        total++; if (acc_words != 32) begin bad++; $display("FAIL credit_words got=%0d want=32", acc_words); end
        total++; if (master_read !== 1'b0) begin bad++; $display("FAIL credit_read_low got=%0b want=0", master_read); end
        pop_budget = 8;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk); #1;
            if (pop_budget == 0) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL credit_pop_timeout got=%0d left want=0", pop_budget); end
        repeat (20) @(posedge Clk);
        #1;
        total++; if (acc_addr_q.size() < 9) begin bad++; $display("FAIL credit_resume got=%0d bursts want>=9", acc_addr_q.size()); end
        else begin
            total++; if (acc_addr_q[8] !== 32'h4020 || acc_bc_q[8] != 4) begin bad++; $display("FAIL credit_burst8 got=%0h/%0d want=4020/4", acc_addr_q[8], acc_bc_q[8]); end
        end
        pop_mode = 1;
        wait_done(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL credit_timeout got=0 want=1"); end
        total++; if (max_inflight > 32) begin bad++; $display("FAIL credit_inflight got=%0d want<=32", max_inflight); end
        total++; if (stream_errs(32'h4000, 40) != 0) begin bad++; $display("FAIL credit_stream got=%0d errors want=0", stream_errs(32'h4000, 40)); end
    endtask

    task automatic test_len0();
        clear_model();
        pop_mode = 1;
        start_xfer(32'h5000, 0);
        repeat (10) @(posedge Clk);
        #1;
        total++; if (read_cycles != 0) begin bad++; $display("FAIL len0_read got=%0d cycles want=0", read_cycles); end
        total++; if (done_low_cycles != 0) begin bad++; $display("FAIL len0_done got=%0d low cycles want=0", done_low_cycles); end
    endtask

    task automatic test_go_ignored();
        bit ok;
        clear_model();
        pop_mode = 2;
        start_xfer(32'h6000, 24);
        control_read_base   = 32'h7700;
        control_read_length = 8;
        control_go          = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        control_go = 1'b0;
        wait_done(600, ok);
        total++; if (!ok) begin bad++; $display("FAIL go2_timeout got=0 want=1"); end
        total++; if (stream_errs(32'h6000, 24) != 0) begin bad++; $display("FAIL go2_stream got=%0d errors want=0", stream_errs(32'h6000, 24)); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_model();
        pop_mode = 0;
        pop_budget = 0;
        start_xfer(32'h8000, 40);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge Clk); #1;
            if (acc_addr_q.size() >= 1) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL rmid_no_issue got=0 want=1"); end
        @(posedge Clk); #1;
        Reset = 1'b0;
        #1;
        total++; if (master_read !== 1'b0 || master_address !== 32'h0 || master_burstcount !== 3'd0) begin bad++; $display("FAIL rmid_master got=%0b/%0h/%0d want=0/0/0", master_read, master_address, master_burstcount); end
        total++; if (control_done !== 1'b1 || control_early_done !== 1'b1) begin bad++; $display("FAIL rmid_done got=%0b/%0b want=1/1", control_done, control_early_done); end
        total++; if (user_data_available !== 1'b0 || user_buffer_output_data !== 8'h0) begin bad++; $display("FAIL rmid_user got=%0b/%0h want=0/0", user_data_available, user_buffer_output_data); end
        resp_q.delete(); ready_q.delete(); last_ready = 0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            resp_q.push_back(32'h8000 + 32'(i));
            ready_q.push_back(cyc + 1 + i);
        end
        last_ready = cyc + 3;
        repeat (10) @(posedge Clk);
        #1;
        total++; if (avail_cycles != 0) begin bad++; $display("FAIL rmid_stray got=%0d avail cycles want=0", avail_cycles); end
        total++; if (read_cycles != 0 || done_low_cycles != 0) begin bad++; $display("FAIL rmid_idle got=%0d/%0d want=0/0", read_cycles, done_low_cycles); end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] base;
        int len;
        for (int it = 0; it < 6; it++) begin
            clear_model();
            base = (it == 0) ? 32'hFFFF_FFFA : $urandom;
            len  = $urandom_range(1, 45);
            rand_wait = 1'b1;
            pop_mode  = 2;
            start_xfer(base, 32'(len));
            wait_done(3000, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand%0d_timeout got=0 want=1", it); end
            total++; if (stream_errs(base, len) != 0) begin bad++; $display("FAIL rand%0d_stream base=%0h len=%0d got=%0d errors want=0", it, base, len, stream_errs(base, len)); end
            total++; if (hold_err != 0 || max_inflight > 32) begin bad++; $display("FAIL rand%0d_bus got=%0d/%0d want=0/<=32", it, hold_err, max_inflight); end
        end
        rand_wait = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_stall();
        test_credit();
        test_len0();
        test_go_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_read_master.md
Name: sprite_read_master

Overview:
- Avalon-MM burst read master that fetches sprite pixel data from SDRAM and serves it to the sprite drawing controller through a go/done control port and a show-ahead byte stream port.
- Responder end of the control/user handshake the sprite controller initiates (read_base, read_length, go, done, early_done, read_buffer, buffer_output_data, data_available).
- Sits between the sprite controller and the system interconnect; buffers returned data in an internal FIFO.

Parameters:
- ADDR_W, 32, Avalon address width (byte addresses).
- DATA_W, 8, pixel/readdata width; 8-bit only, so 1 byte per word.
- MAX_BURST, 4, maximum burstcount issued (power of two).
- BURST_W, 3, width of master_burstcount; must hold MAX_BURST.
- FIFO_DEPTH, 32, buffer words (power of two, >= 2*MAX_BURST).

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-low reset
- control_read_base  in  ADDR_W  first byte address; sampled on accepted go
- control_read_length  in  32  bytes to read; sampled on accepted go
- control_go  in  1  start request; level or pulse
- control_done  out  1  idle: all data issued, returned and popped
- control_early_done  out  1  no further reads remain to be issued
- user_read_buffer  in  1  pop FIFO head
- user_buffer_output_data  out  DATA_W  FIFO head (show-ahead)
- user_data_available  out  1  FIFO not empty
- master_address  out  ADDR_W  burst start address
- master_read  out  1  read request
- master_burstcount  out  BURST_W  words in current burst
- master_readdata  in  DATA_W  returned data
- master_readdatavalid  in  1  readdata valid
- master_waitrequest  in  1  slave stall

Behaviour:
- Reset (Reset low, async): state IDLE; master_read 0, master_address 0, master_burstcount 0; control_done 1, control_early_done 1; user_data_available 0, user_buffer_output_data 0; FIFO, outstanding and remaining counters cleared.
- States: IDLE, ISSUE, DRAIN.
- IDLE: control_go=1 and control_read_length!=0 -> latch base/length into addr_reg/remaining, go to ISSUE; control_done and early_done drop to 0 the next cycle. If length==0, go is ignored and outputs stay idle.
- control_go in ISSUE/DRAIN is ignored.
- ISSUE: burst = min(MAX_BURST, remaining). Assert master_read only when FIFO_DEPTH - fifo_used - outstanding >= burst; this rule makes overflow impossible.
- Burst acceptance is the cycle with master_read=1 and master_waitrequest=0. On acceptance: addr_reg += burst, remaining -= burst, outstanding += burst.
- While waitrequest=1, master_address, master_burstcount and master_read are held stable.
- When remaining reaches 0 on an acceptance, go to DRAIN; control_early_done=1 from the next cycle.
- Earliest master_read is the cycle after go is sampled.
- master_readdatavalid: push readdata and decrement outstanding, in the same cycle an acceptance may increment it; net update is +burst-1.
- readdatavalid with outstanding==0 (stray response after reset) is dropped.
- DRAIN: when outstanding==0 and FIFO empty -> IDLE; control_done=1 the next cycle.
- FIFO is show-ahead: user_buffer_output_data shows the head whenever user_data_available=1. A pushed word becomes visible the cycle after the push.
- user_read_buffer pops one word per cycle; a pop on empty is ignored.
- Push and pop in the same cycle when non-empty: both happen, count unchanged. Push while empty plus pop: pop ignored.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Address arithmetic is modulo 2^ADDR_W; no 4 KB/boundary splitting.
- Reset mid-operation aborts immediately; buffered data is discarded.

Decomposition:
- Package sprite_dma_pkg: state enum (IDLE/ISSUE/DRAIN), default MAX_BURST/FIFO_DEPTH constants.
- One sub-module, sprite_fifo: synchronous show-ahead FIFO with push, pop, data, empty, used; same Clk/Reset.
- Burst sizing and the credit check stay in sprite_read_master.

Test Plan:
- base 0x1000, length 12, no waitrequest, 2-cycle read latency, user pops continuously -> three bursts at 0x1000/0x1004/0x1008, burstcount 4; early_done after the 3rd acceptance; bytes 0..11 delivered in order; done=1 one cycle after DRAIN exits.
- length 6 -> bursts of 4 at base, then 2 at base+4; exactly 6 pushes; done returns to 1.
- waitrequest held 3 cycles on the first burst -> address/burstcount/read stable through the stall; exactly one acceptance recorded.
- length 40, user never pops -> issued-but-unpopped words never exceed 32; master_read stays low once credit is exhausted; after 8 pops a new 4-burst is issued.
- go with length 0 -> no master_read, done stays 1. Second go during ISSUE with a different base -> ignored, original addresses continue.
- Reset low mid-ISSUE with 4 outstanding -> all outputs at reset values; later stray readdatavalid pulses do not set data_available.
